// File: rtl/bt_pkg.sv
// Shared definitions for the Bluetooth UART transmit scheduler.
//   tx_state_e       : serial frame sequencing states
//   DATA_W           : byte width (8N1 framing)
//   FRAME_BITS       : start + 8 data + stop
//   CLKS_PER_BIT_DEF : 50 MHz board clock / 9600 baud
package bt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_W           = 8;
    localparam int FRAME_BITS       = 10;
    localparam int CLKS_PER_BIT_DEF = 5208;

endpackage

// File: rtl/bt_uart_tx_core.sv
// 8N1 serial framer: start bit, 8 data bits LSB first, stop bit, each held
// for CLKS_PER_BIT clocks.
//   clk, rst : board clock, synchronous active-high reset
//   start    : accepted only while idle; latches byte_in and drives tx low
//              on the same edge
//   byte_in  : byte to send
//   tx       : serial line, idle high (registered)
//   busy     : high from the start edge until the end of the stop bit
//   done     : high during the last clock of the stop bit
module bt_uart_tx_core
    import bt_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] byte_in,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                // Baud counter is parked at 0 so the start bit is a full period.
                if (start) begin
                    state_d = START;
                    shreg_d = byte_in;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                    tx_d    = shreg_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        // Shift out the bit just sent; next bit is shreg_q[1].
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done    = 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: rtl/bt_uart_tx_sched.sv
// Round-robin scheduler sharing one UART tx line among N_REQ byte requesters.
//   clk, rst : board clock, synchronous active-high reset
//   req      : per-requester request, held until ack
//   data     : byte of requester i at [i*DATA_W +: DATA_W]
//   ack      : one-cycle one-hot pulse, the byte of that requester was latched
//   grant_id : requester owning the current or last frame
//   busy     : frame in progress
//   tx       : serial line, idle high
module bt_uart_tx_sched #(
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = bt_pkg::CLKS_PER_BIT_DEF,
    parameter int DATA_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DATA_W-1:0]  data,
    output logic [N_REQ-1:0]         ack,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     tx
);

    import bt_pkg::*;

    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [ID_W-1:0]   win, idx;
    logic [DATA_W-1:0] win_byte;
    logic              found, start;
    logic              core_busy;
    logic              core_done_unused;

    // First set request at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ID_W'((int'(ptr_q) + i) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == ID_W'(i)) win_byte = data[i*DATA_W +: DATA_W];
        end
    end

    // Arbitration only while the framer is idle; busy drops on the edge that
    // ends the stop bit, so the idle cycle between frames is the grant cycle.
    assign start = found && !core_busy;

    always_comb begin
        ptr_d   = ptr_q;
        grant_d = grant_q;
        ack_d   = '0;
        if (start) begin
            grant_d = win;
            ptr_d   = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
            for (int i = 0; i < N_REQ; i++) ack_d[i] = (win == ID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
        end
    end

    // done is not needed here: busy alone marks when the line is free.
    bt_uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .byte_in(win_byte),
        .tx     (tx),
        .busy   (core_busy),
        .done   (core_done_unused)
    );

    assign ack      = ack_q;
    assign grant_id = grant_q;
    assign busy     = core_busy;

endmodule

// File: doc/bt_uart_tx_sched.md
Name: bt_uart_tx_sched

Overview:
Round-robin scheduler that shares the single Bluetooth UART transmit line (to the HC-05-class module) among N_REQ byte requesters. It arbitrates between pending requests, latches the winning byte, acknowledges it and sequences an 8N1 serial frame on tx. It sits between the application request sources and the Bluetooth module pin, clocked from the board clock.

Parameters:
N_REQ, 4, number of requesters (2..8)
CLKS_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600 baud); minimum 2
DATA_W, 8, byte width; fixed 8 for 8N1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester request; held high until ack
data  in  N_REQ*DATA_W  byte for requester i at bits [i*8 +: 8]
ack  out  N_REQ  one-cycle one-hot pulse: byte of requester i latched
grant_id  out  $clog2(N_REQ)  index of the requester owning the current or last frame
busy  out  1  high while a frame is in progress
tx  out  1  serial line to the Bluetooth module, idle high

Behaviour:
- Reset values: tx=1, ack=0, busy=0, grant_id=0, round-robin pointer=0 (requester 0 highest priority first), state=IDLE.
- One clock, synchronous, active-high reset; reset has priority over every other event.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE: at an edge where req!=0, pick the first set req at or after the pointer, wrapping modulo N_REQ. Same edge: latch the byte, ack<=onehot(winner) for exactly one cycle, grant_id<=winner, pointer<=winner+1 mod N_REQ, busy<=1, tx<=0, state<=START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: 8 bits LSB first, each CLKS_PER_BIT cycles. A 3-bit counter wraps 7->0 and moves to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE with busy<=0.
- A frame is 10*CLKS_PER_BIT cycles from the first tx low to the end of the stop bit.
- Back-to-back frames: at least one IDLE cycle with tx=1 between the stop bit and the next start bit. Arbitration happens in that cycle.
- req is sampled only in IDLE. A req that drops before ack is never sent and never acked. A req still high one cycle after ack counts as a new request and competes again under round-robin.
- data is sampled only on the grant edge; changes to data during the frame have no effect.
- Reset mid-frame: on the next edge tx=1 and busy=0, the frame is aborted, no ack is issued and the pointer returns to 0.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, reloads at bit boundaries and does not run in IDLE.

Decomposition:
- Shared package bt_pkg:
  - state enum {IDLE, START, DATA, STOP}
  - DATA_W=8, FRAME_BITS=10
  - default CLKS_PER_BIT constant
- Sub-module bt_uart_tx_core:
  - handles START/DATA/STOP sequencing, the baud counter and the bit counter.
  - interface: start, byte_in, tx, busy, done.
- Top bt_uart_tx_sched holds:
  - the round-robin pointer and the priority pick
  - ack generation
  - grant_id
  - the start pulse to the core

Test Plan:
(All scenarios use CLKS_PER_BIT=4, N_REQ=4.)
1. Single byte: req[1]=1, data1=0xA5 after reset.
   - ack=4'b0010 for one cycle, grant_id=1.
   - tx bits (4 cycles each): 0,1,0,1,0,0,1,0,1,1.
   - busy high for exactly 40 cycles.
2. Simultaneous requests: req=4'b1111, bytes 0x11/0x22/0x33/0x44, each req dropped on its ack.
   - Grants in order 0,1,2,3; four frames carry those bytes.
   - Exactly one tx-high idle cycle between frames.
3. Fairness: req[0] and req[2] held continuously.
   - grant_id sequence 0,2,0,2; requester 0 never wins twice in a row.
4. Reset mid-frame: rst=1 for one cycle at cycle 15 of a 0x3C frame.
   - Next cycle tx=1, busy=0; no further bits.
   - A subsequent req=4'b1010 grants requester 1 (pointer reset to 0).
5. Transient request: req[3] pulsed during a busy frame and dropped before the frame ends.
   - ack[3] never asserts; no extra frame follows.
6. Data stability: data0 changes from 0x55 to 0xFF mid-frame.
   - Transmitted byte remains 0x55.
